// File: rtl/md_pkg.sv
// Shared constants, opcode encodings and FSM state type for the execute-stage mul/div unit.
package md_pkg;

  localparam int unsigned MdWidth = 32;

  localparam logic [2:0] OpMultu = 3'b000;
  localparam logic [2:0] OpDivu  = 3'b001;
  localparam logic [2:0] OpMfhi  = 3'b010;
  localparam logic [2:0] OpMflo  = 3'b011;
  localparam logic [2:0] OpMult  = 3'b100;
  localparam logic [2:0] OpDiv   = 3'b101;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Pipeline-facing bundle of the mul/div unit: decoded EX-stage request in, HI/LO and stall out.
interface ex_muldiv_unit_if;
  import md_pkg::*;

  logic               valid;
  logic [2:0]         mdOp;
  logic               flush;
  logic [MdWidth-1:0] opA;
  logic [MdWidth-1:0] opB;
  logic               stall;
  logic               busy;
  logic [MdWidth-1:0] hiOut;
  logic [MdWidth-1:0] loOut;
  logic [MdWidth-1:0] mdResult;
  logic               divByZero;

  modport master (
    output valid, mdOp, flush, opA, opB,
    input  stall, busy, hiOut, loOut, mdResult, divByZero
  );

  modport slave (
    input  valid, mdOp, flush, opA, opB,
    output stall, busy, hiOut, loOut, mdResult, divByZero
  );

endinterface

// File: rtl/md_iter_core.sv
// Iterative datapath: shift-add multiply and restoring divide sharing one 64-bit working register.
module md_iter_core
  import md_pkg::*;
#(
  parameter int unsigned ITER = MdWidth
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               run,
  input  logic               is_div,
  input  logic [MdWidth-1:0] opa,
  input  logic [MdWidth-1:0] opb,
  output logic               done,
  output logic [MdWidth-1:0] step_hi,
  output logic [MdWidth-1:0] step_lo
);

  localparam int unsigned W = MdWidth;

  logic [2*W-1:0] work_q, work_d;
  logic [W-1:0]   opnd_q;
  logic           div_q;
  logic [5:0]     cnt_q;

  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic [W+1:0]   div_diff;

  // Multiply: work = {partial product, remaining multiplier bits}.
  // Divide:   work = {partial remainder, dividend bits shifting into quotient}.
  always_comb begin
    mul_sum   = {1'b0, work_q[2*W-1:W]} + (work_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {work_q[2*W-1:W], work_q[W-1]};
    // Extra guard bit: the shifted remainder can exceed 2^32 when the divisor is large.
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    if (div_q) begin
      if (!div_diff[W+1]) work_d = {div_diff[W-1:0], work_q[W-2:0], 1'b1};
      else                work_d = {div_shift[W-1:0], work_q[W-2:0], 1'b0};
    end else begin
      work_d = {mul_sum, work_q[W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work_q <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      work_q <= {{W{1'b0}}, (is_div ? opa : opb)};
      opnd_q <= is_div ? opb : opa;
      div_q  <= is_div;
      cnt_q  <= '0;
    end else if (run) begin
      work_q <= work_d;
      cnt_q  <= cnt_q + 6'd1;
    end
  end

  assign done    = run && (cnt_q == 6'(ITER - 1));
  assign step_hi = work_d[2*W-1:W];
  assign step_lo = work_d[W-1:0];

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multi-cycle mul/div unit owning architectural HI/LO and the pipeline stall.
// Signed MULT/DIV support is compiled in when MULDIV_SIGNED_EN is defined.
module ex_muldiv_unit
  import md_pkg::*;
#(
  parameter int unsigned ITER = MdWidth
) (
  input logic              clk,
  input logic              rst,
  ex_muldiv_unit_if.slave  md
);

  md_state_e          state_q;
  logic [MdWidth-1:0] hi_q, lo_q;
  logic               dbz_q;

  logic               busy;
  logic               op_defined, op_start, accept, is_div, done;
  logic [MdWidth-1:0] opa_mag, opb_mag;
  logic [MdWidth-1:0] step_hi, step_lo, res_hi, res_lo;
  logic [MdWidth-1:0] md_result;

  always_comb begin
    op_defined = 1'b0;
    op_start   = 1'b0;
    case (md.mdOp)
      OpMultu, OpDivu: begin
        op_defined = 1'b1;
        op_start   = 1'b1;
      end
      OpMfhi, OpMflo: op_defined = 1'b1;
`ifdef MULDIV_SIGNED_EN
      OpMult, OpDiv: begin
        op_defined = 1'b1;
        op_start   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign busy   = (state_q == StBusy);
  assign is_div = md.mdOp[0];
  assign accept = (state_q == StIdle) && md.valid && !md.flush && op_start;

`ifdef MULDIV_SIGNED_EN
  logic sign_a, sign_b;
  logic mul_q, neg_lo_q, neg_hi_q;

  assign sign_a  = md.mdOp[2] & md.opA[MdWidth-1];
  assign sign_b  = md.mdOp[2] & md.opB[MdWidth-1];
  assign opa_mag = sign_a ? -md.opA : md.opA;
  assign opb_mag = sign_b ? -md.opB : md.opB;

  // Divide by zero keeps the raw unsigned result, so its correction flags are cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else if (accept) begin
      mul_q <= !is_div;
      if (is_div) begin
        neg_lo_q <= (md.opB != '0) && (sign_a ^ sign_b);
        neg_hi_q <= (md.opB != '0) && sign_a;
      end else begin
        neg_lo_q <= sign_a ^ sign_b;
        neg_hi_q <= 1'b0;
      end
    end
  end

  always_comb begin
    res_hi = step_hi;
    res_lo = step_lo;
    if (mul_q) begin
      if (neg_lo_q) {res_hi, res_lo} = -{step_hi, step_lo};
    end else begin
      if (neg_lo_q) res_lo = -step_lo;
      if (neg_hi_q) res_hi = -step_hi;
    end
  end
`else
  assign opa_mag = md.opA;
  assign opb_mag = md.opB;
  assign res_hi  = step_hi;
  assign res_lo  = step_lo;
`endif

  md_iter_core #(
    .ITER (ITER)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (accept),
    .run     (busy),
    .is_div  (is_div),
    .opa     (opa_mag),
    .opb     (opb_mag),
    .done    (done),
    .step_hi (step_hi),
    .step_lo (step_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      dbz_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StBusy;
            dbz_q   <= is_div && (md.opB == '0);
          end
        end
        StBusy: begin
          if (done) begin
            state_q <= StIdle;
            hi_q    <= res_hi;
            lo_q    <= res_lo;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    md_result = '0;
    if (md.valid) begin
      if (md.mdOp == OpMfhi)      md_result = hi_q;
      else if (md.mdOp == OpMflo) md_result = lo_q;
    end
  end

  assign md.busy      = busy;
  assign md.stall     = md.valid && !md.flush && busy && op_defined;
  assign md.hiOut     = hi_q;
  assign md.loOut     = lo_q;
  assign md.mdResult  = md_result;
  assign md.divByZero = dbz_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized self-checking bench for ex_muldiv_unit against an arithmetic HI/LO reference model.
module tb_ex_muldiv_unit;

  localparam int ITER = 32;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  ex_muldiv_unit_if mif ();

  ex_muldiv_unit #(
    .ITER (ITER)
  ) dut (
    .clk (clk),
    .rst (rst),
    .md  (mif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef MULDIV_SIGNED_EN
  localparam bit Signed = 1'b1;
`else
  localparam bit Signed = 1'b0;
`endif

  function automatic bit op_is_div(input logic [2:0] op);
    return (op == 3'd1) || (Signed && op == 3'd5);
  endfunction

  // Reference: HI/LO after an operation, from plain integer arithmetic.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] ehi, output logic [31:0] elo);
    logic [63:0] p;
    longint      sa, sb, q, r;
    ehi = hi_m;
    elo = lo_m;
    if (op == 3'd0) begin
      p = {32'd0, a} * {32'd0, b};
      ehi = p[63:32];
      elo = p[31:0];
    end else if (op == 3'd1 || (Signed && op == 3'd5 && b == 0)) begin
      if (b == 0) begin
        ehi = a;
        elo = 32'hFFFF_FFFF;
      end else begin
        ehi = a % b;
        elo = a / b;
      end
    end else if (Signed && op == 3'd4) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p = 64'(sa * sb);
      ehi = p[63:32];
      elo = p[31:0];
    end else if (Signed && op == 3'd5) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      r = sa % sb;
      ehi = r[31:0];
      elo = q[31:0];
    end
  endtask

  // Issue op in the current cycle; while busy present 'follow' traffic:
  // 0 none, 1 MFHI/MFLO (nop), 2 flushed nop, 3 stalled new op, 4 reserved nop.
  // Returns in the cycle after completion with the follow-up still driven.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int follow, input logic [2:0] nop, input logic [31:0] na,
                       input logic [31:0] nb);
    logic [31:0] old_hi, old_lo, ehi, elo, exp_res;
    bit          dz;
    old_hi = hi_m;
    old_lo = lo_m;
    model(op, a, b, ehi, elo);
    dz = op_is_div(op) && (b == 0);
    mif.valid = 1'b1; mif.mdOp = op; mif.opA = a; mif.opB = b; mif.flush = 1'b0;
    #1;
    chk("accept_stall", mif.stall, 0);
    chk("accept_busy", mif.busy, 0);
    tick();
    mif.mdOp = nop; mif.opA = na; mif.opB = nb;
    mif.valid = (follow != 0);
    mif.flush = (follow == 2);
    for (int k = 1; k <= ITER; k++) begin
      #1;
      chk("busy", mif.busy, 1);
      chk("hi_hold", mif.hiOut, old_hi);
      chk("lo_hold", mif.loOut, old_lo);
      chk("stall", mif.stall, (follow == 1) || (follow == 3));
      exp_res = (follow == 1) ? ((nop == 3'd2) ? old_hi : old_lo) : 32'd0;
      chk("mdresult_busy", mif.mdResult, exp_res);
      if (k <= 2) chk("div_by_zero", mif.divByZero, (k == 1) && dz);
      tick();
    end
    hi_m = ehi;
    lo_m = elo;
    #1;
    chk("done_busy", mif.busy, 0);
    chk("hi", mif.hiOut, hi_m);
    chk("lo", mif.loOut, lo_m);
    chk("done_stall", mif.stall, 0);
    exp_res = (follow == 1) ? ((nop == 3'd2) ? hi_m : lo_m) : 32'd0;
    chk("mdresult_done", mif.mdResult, exp_res);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  op, nop;
    logic [31:0] a, b;
    int          follow;

    rst = 1'b1;
    mif.valid = 1'b0; mif.mdOp = 3'd0; mif.flush = 1'b0; mif.opA = '0; mif.opB = '0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("rst_busy", mif.busy, 0);
    chk("rst_stall", mif.stall, 0);
    chk("rst_hi", mif.hiOut, 0);
    chk("rst_lo", mif.loOut, 0);
    chk("rst_mdresult", mif.mdResult, 0);
    chk("rst_dbz", mif.divByZero, 0);

    do_op(3'd0, 32'h0000_FFFF, 32'h0001_0001, 0, 3'd0, 0, 0);
    do_op(3'd1, 32'd100, 32'd7, 1, 3'd3, 0, 0);
    do_op(3'd1, 32'd5, 32'd0, 0, 3'd0, 0, 0);

    // Reset in cycle 10 of a MULTU.
    mif.valid = 1'b1; mif.mdOp = 3'd0; mif.opA = 32'h1234_5678; mif.opB = 32'h9;
    tick();
    mif.valid = 1'b0;
    repeat (9) tick();
    #1;
    chk("midop_busy", mif.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hi_m = '0;
    lo_m = '0;
    #1;
    chk("midrst_busy", mif.busy, 0);
    chk("midrst_hi", mif.hiOut, 0);
    chk("midrst_lo", mif.loOut, 0);
    mif.valid = 1'b1; mif.mdOp = 3'd2;
    #1;
    chk("midrst_mfhi_stall", mif.stall, 0);
    chk("midrst_mfhi", mif.mdResult, 0);

    // Reset coinciding with the completion edge.
    mif.mdOp = 3'd0; mif.opA = 32'hFFFF_FFFF; mif.opB = 32'hFFFF_FFFF;
    tick();
    mif.valid = 1'b0;
    repeat (ITER - 1) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rstwin_busy", mif.busy, 0);
    chk("rstwin_hi", mif.hiOut, 0);
    chk("rstwin_lo", mif.loOut, 0);

    // Flushed MULTU in IDLE is not accepted.
    do_op(3'd1, 32'd77, 32'd10, 0, 3'd0, 0, 0);
    mif.valid = 1'b1; mif.flush = 1'b1; mif.mdOp = 3'd0; mif.opA = 32'd3; mif.opB = 32'd4;
    tick();
    #1;
    chk("flush_busy", mif.busy, 0);
    chk("flush_hi", mif.hiOut, hi_m);
    chk("flush_lo", mif.loOut, lo_m);
    mif.flush = 1'b0;

    // DIV -7 / 2: signed result, or ignored in the unsigned build.
    if (Signed) begin
      do_op(3'd5, 32'hFFFF_FFF9, 32'd2, 0, 3'd0, 0, 0);
      chk("sdiv_lo", mif.loOut, 32'hFFFF_FFFD);
      chk("sdiv_hi", mif.hiOut, 32'hFFFF_FFFF);
    end else begin
      mif.valid = 1'b1; mif.mdOp = 3'd5; mif.opA = 32'hFFFF_FFF9; mif.opB = 32'd2;
      #1;
      chk("udiv_rsv_stall", mif.stall, 0);
      chk("udiv_rsv_mdresult", mif.mdResult, 0);
      tick();
      #1;
      chk("udiv_rsv_busy", mif.busy, 0);
      chk("udiv_rsv_hi", mif.hiOut, hi_m);
      chk("udiv_rsv_lo", mif.loOut, lo_m);
    end

    // Back-to-back: second op stalled from cycle 1, accepted in cycle 33.
    do_op(3'd0, 32'hDEAD_BEEF, 32'h0000_0100, 3, 3'd1, 32'hFFFF_FFFF, 32'd3);
    do_op(3'd1, 32'hFFFF_FFFF, 32'd3, 2, 3'd0, 32'd1, 32'd1);
    do_op(3'd0, 32'h8000_0001, 32'h7FFF_FFFF, 4, (Signed ? 3'd6 : 3'd4), 0, 0);

    for (int i = 0; i < 16; i++) begin
      op = Signed ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 1));
      if (op > 3'd1) op = op + 3'd2;
      a = $urandom;
      b = rnd_opnd();
      follow = $urandom_range(0, 3);
      if (follow == 3) follow = 4;
      case (follow)
        1:       nop = 3'($urandom_range(2, 3));
        4:       nop = Signed ? 3'($urandom_range(6, 7)) : 3'($urandom_range(4, 7));
        default: nop = 3'd0;
      endcase
      do_op(op, a, b, follow, nop, $urandom, $urandom);
      mif.valid = 1'b0;
      mif.flush = 1'b0;
    end

    mif.valid = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
